// File: rtl/demux_pkg.sv
// Shared types for the 1-to-2 stream demultiplexer.
package demux_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ROUTE0,
    ROUTE1
  } state_t;

  localparam int unsigned N_OUT = 2;

endpackage

// File: rtl/demux_out_reg.sv
// One-entry registered output slot; drain and refill may happen in the same cycle.
module demux_out_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             d_last,
  input  logic             ready,
  output logic [WIDTH-1:0] q,
  output logic             q_last,
  output logic             valid,
  output logic             free
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             last_q, last_d;
  logic             valid_q, valid_d;

  always_comb begin
    data_d  = data_q;
    last_d  = last_q;
    valid_d = valid_q;
    if (valid_q && ready) begin
      valid_d = 1'b0;
    end
    if (load) begin
      valid_d = 1'b1;
      data_d  = d;
      last_d  = d_last;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_q  <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      last_q  <= last_d;
      valid_q <= valid_d;
    end
  end

  assign q      = data_q;
  assign q_last = last_q;
  assign valid  = valid_q;
  assign free   = !valid_q || ready;

endmodule

// File: rtl/demux_1x2_stream.sv
// 1-to-2 valid/ready stream demultiplexer with packet-sticky routing.
// Optional per-output handshake counters (cnt0/cnt1) when DEMUX_STATS_EN is defined.
module demux_1x2_stream
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_last,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_last,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_last,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic             busy
`ifdef DEMUX_STATS_EN
  ,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
`endif
);

  state_t           state_q, state_d;
  logic             dest;
  logic             accept;
  logic [N_OUT-1:0] slot_free;
  logic [N_OUT-1:0] slot_load;

  always_comb begin
    dest = in_sel;
    unique case (state_q)
      IDLE:    dest = in_sel;
      ROUTE0:  dest = 1'b0;
      ROUTE1:  dest = 1'b1;
      default: dest = in_sel;
    endcase
  end

  assign in_ready     = slot_free[dest];
  assign accept       = in_valid && in_ready;
  assign slot_load[0] = accept && !dest;
  assign slot_load[1] = accept && dest;

  always_comb begin
    state_d = state_q;
    if (accept) begin
      if (in_last) begin
        state_d = IDLE;
      end else if (state_q == IDLE) begin
        state_d = in_sel ? ROUTE1 : ROUTE0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign busy = (state_q != IDLE);

  demux_out_reg #(.WIDTH(WIDTH)) u_slot0 (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (slot_load[0]),
    .d       (in_data),
    .d_last  (in_last),
    .ready   (out0_ready),
    .q       (out0_data),
    .q_last  (out0_last),
    .valid   (out0_valid),
    .free    (slot_free[0])
  );

  demux_out_reg #(.WIDTH(WIDTH)) u_slot1 (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (slot_load[1]),
    .d       (in_data),
    .d_last  (in_last),
    .ready   (out1_ready),
    .q       (out1_data),
    .q_last  (out1_last),
    .valid   (out1_valid),
    .free    (slot_free[1])
  );

`ifdef DEMUX_STATS_EN
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (out0_valid && out0_ready) cnt0_d = cnt0_q + 1'b1;
    if (out1_valid && out1_ready) cnt1_d = cnt1_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign cnt0 = cnt0_q;
  assign cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_demux_1x2_stream.sv
module tb_demux_1x2_stream;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] in_data;
  logic       in_sel, in_last, in_valid, in_ready;
  logic [7:0] out0_data, out1_data;
  logic       out0_last, out0_valid, out0_ready;
  logic       out1_last, out1_valid, out1_ready;
  logic       busy;
`ifdef DEMUX_STATS_EN
  logic [15:0] cnt0, cnt1;
  logic [15:0] m_cnt0 = '0, m_cnt1 = '0;
`endif

  int checks = 0;
  int errors = 0;

  // reference model: per-output queue of pending beats ({last,data}) and packet routing state
  logic [8:0] mq0[$];
  logic [8:0] mq1[$];
  logic       m_inpkt = 1'b0;
  logic       m_dest  = 1'b0;

  // per-cycle observations recorded by cyc()
  logic       rdy_s, rdy_e;
  logic       hs0_dut, hs1_dut, hs0_mod, hs1_mod;
  logic [8:0] hs0_dut_d, hs1_dut_d, hs0_mod_d, hs1_mod_d;

  always #5 clk = ~clk;

  demux_1x2_stream #(.WIDTH(8), .CNT_W(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_last    (in_last),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out0_data  (out0_data),
    .out0_last  (out0_last),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out1_data  (out1_data),
    .out1_last  (out1_last),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .busy       (busy)
`ifdef DEMUX_STATS_EN
    ,
    .cnt0       (cnt0),
    .cnt1       (cnt1)
`endif
  );

  // Drive one cycle, record pre-edge observations, advance the model across the edge.
  task automatic cyc(input logic rn, input logic v, input logic s, input logic l,
                     input logic [7:0] d, input logic r0, input logic r1);
    logic dst;
    logic acc;
    @(negedge clk);
    reset_n = rn; in_valid = v; in_sel = s; in_last = l; in_data = d;
    out0_ready = r0; out1_ready = r1;
    #1;
    rdy_s = in_ready;
    dst   = m_inpkt ? m_dest : s;
    rdy_e = dst ? (mq1.size() == 0 || r1) : (mq0.size() == 0 || r0);
    hs0_dut = out0_valid && r0;  hs0_dut_d = {out0_last, out0_data};
    hs1_dut = out1_valid && r1;  hs1_dut_d = {out1_last, out1_data};
    hs0_mod = (mq0.size() != 0) && r0;  hs0_mod_d = hs0_mod ? mq0[0] : '0;
    hs1_mod = (mq1.size() != 0) && r1;  hs1_mod_d = hs1_mod ? mq1[0] : '0;
    acc = rn && v && rdy_e;
    @(posedge clk);
    if (!rn) begin
      mq0.delete(); mq1.delete(); m_inpkt = 1'b0;
`ifdef DEMUX_STATS_EN
      m_cnt0 = '0; m_cnt1 = '0;
`endif
    end else begin
      if (hs0_mod) begin
        void'(mq0.pop_front());
`ifdef DEMUX_STATS_EN
        m_cnt0 = m_cnt0 + 16'd1;
`endif
      end
      if (hs1_mod) begin
        void'(mq1.pop_front());
`ifdef DEMUX_STATS_EN
        m_cnt1 = m_cnt1 + 16'd1;
`endif
      end
      if (acc) begin
        if (dst) mq1.push_back({l, d});
        else     mq0.push_back({l, d});
        if (l) m_inpkt = 1'b0;
        else if (!m_inpkt) begin
          m_inpkt = 1'b1;
          m_dest  = s;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    for (int unsigned i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b1);
    checks++; if (out0_valid !== 1'b0) begin errors++; $display("FAIL reset_out0_valid got %b exp 0", out0_valid); end
    checks++; if (out1_valid !== 1'b0) begin errors++; $display("FAIL reset_out1_valid got %b exp 0", out1_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (out0_data !== 8'h00) begin errors++; $display("FAIL reset_out0_data got %h exp 00", out0_data); end
    @(negedge clk);
    reset_n = 1'b1; in_valid = 1'b0; in_sel = 1'b0; out0_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_single_beat();
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b1);
    checks++; if (rdy_s !== 1'b1) begin errors++; $display("FAIL single_in_ready got %b exp 1", rdy_s); end
    checks++; if ({out1_valid, out1_last, out1_data} !== {1'b1, 1'b1, 8'hA5})
      begin errors++; $display("FAIL single_out1 got v%b l%b %h exp v1 l1 a5", out1_valid, out1_last, out1_data); end
    checks++; if (out0_valid !== 1'b0) begin errors++; $display("FAIL single_out0_valid got %b exp 0", out0_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy got %b exp 0", busy); end
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    checks++; if (out1_valid !== 1'b0) begin errors++; $display("FAIL single_drain got %b exp 0", out1_valid); end
  endtask

  task automatic test_sticky();
    logic [7:0] dat [3];
    logic       sel [3];
    dat[0] = 8'h11; dat[1] = 8'h22; dat[2] = 8'h33;
    sel[0] = 1'b0;  sel[1] = 1'b1;  sel[2] = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b1, sel[i], (i == 2), dat[i], 1'b1, 1'b1);
      checks++; if ({out0_valid, out0_last, out0_data} !== {1'b1, (i == 2), dat[i]})
        begin errors++; $display("FAIL sticky_out0[%0d] got v%b l%b %h exp v1 l%b %h", i, out0_valid, out0_last, out0_data, (i == 2), dat[i]); end
      checks++; if (out1_valid !== 1'b0) begin errors++; $display("FAIL sticky_out1_valid[%0d] got %b exp 0", i, out1_valid); end
      checks++; if (busy !== (i != 2)) begin errors++; $display("FAIL sticky_busy[%0d] got %b exp %b", i, busy, (i != 2)); end
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
  endtask

  task automatic test_backpressure();
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'h44, 1'b0, 1'b1);
    checks++; if ({out0_valid, out0_data} !== {1'b1, 8'h44}) begin errors++; $display("FAIL bp_load44 got v%b %h exp v1 44", out0_valid, out0_data); end
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 8'h55, 1'b0, 1'b1);
    checks++; if (rdy_s !== 1'b0) begin errors++; $display("FAIL bp_in_ready_stalled got %b exp 0", rdy_s); end
    checks++; if ({out0_valid, out0_last, out0_data} !== {1'b1, 1'b0, 8'h44}) begin errors++; $display("FAIL bp_hold got v%b l%b %h exp v1 l0 44", out0_valid, out0_last, out0_data); end
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 8'h55, 1'b1, 1'b1);
    checks++; if (rdy_s !== 1'b1) begin errors++; $display("FAIL bp_in_ready_refill got %b exp 1", rdy_s); end
    checks++; if ({hs0_dut, hs0_dut_d} !== {1'b1, 1'b0, 8'h44}) begin errors++; $display("FAIL bp_drain44 got hs%b %h exp hs1 044", hs0_dut, hs0_dut_d); end
    checks++; if ({out0_valid, out0_last, out0_data} !== {1'b1, 1'b1, 8'h55}) begin errors++; $display("FAIL bp_load55 got v%b l%b %h exp v1 l1 55", out0_valid, out0_last, out0_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_busy got %b exp 0", busy); end
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
  endtask

  task automatic test_back_to_back();
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 8'h66, 1'b0, 1'b1);
    for (int unsigned i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b1, 1'b1, (i == 7), 8'h80 + 8'(i), 1'b0, 1'b1);
      checks++; if (rdy_s !== 1'b1) begin errors++; $display("FAIL b2b_in_ready[%0d] got %b exp 1", i, rdy_s); end
      checks++; if ({out1_valid, out1_data} !== {1'b1, 8'h80 + 8'(i)}) begin errors++; $display("FAIL b2b_out1[%0d] got v%b %h exp v1 %h", i, out1_valid, out1_data, 8'h80 + 8'(i)); end
      checks++; if ({out0_valid, out0_data} !== {1'b1, 8'h66}) begin errors++; $display("FAIL b2b_out0_held[%0d] got v%b %h exp v1 66", i, out0_valid, out0_data); end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy got %b exp 0", busy); end
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    checks++; if ({hs0_dut, hs0_dut_d} !== {1'b1, 1'b1, 8'h66}) begin errors++; $display("FAIL b2b_drain66 got hs%b %h exp hs1 166", hs0_dut, hs0_dut_d); end
    checks++; if ({out0_valid, out1_valid} !== 2'b00) begin errors++; $display("FAIL b2b_empty got %b%b exp 00", out0_valid, out1_valid); end
  endtask

  task automatic test_reset_mid_packet();
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 8'h77, 1'b1, 1'b0);
    checks++; if ({busy, out1_valid} !== 2'b11) begin errors++; $display("FAIL rmid_pre got busy%b v%b exp 11", busy, out1_valid); end
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h99, 1'b1, 1'b0);
    checks++; if ({busy, out0_valid, out1_valid} !== 3'b000) begin errors++; $display("FAIL rmid_reset got busy%b v0%b v1%b exp 000", busy, out0_valid, out1_valid); end
`ifdef DEMUX_STATS_EN
    checks++; if (cnt1 !== 16'd0) begin errors++; $display("FAIL rmid_cnt1 got %0d exp 0", cnt1); end
`endif
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 8'h88, 1'b1, 1'b1);
    checks++; if ({out0_valid, out0_data, out1_valid} !== {1'b1, 8'h88, 1'b0}) begin errors++; $display("FAIL rmid_after got v0%b %h v1%b exp v0 1 88 v1 0", out0_valid, out0_data, out1_valid); end
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
  endtask

  task automatic test_random();
    logic v, s, l, r0, r1;
    logic [7:0] d;
    logic hold;
    hold = 1'b0; v = 1'b0; s = 1'b0; l = 1'b0; d = '0;
    for (int unsigned n = 0; n < 400; n++) begin
      if (!hold) begin
        v = ($urandom_range(3) != 0);
        s = $urandom_range(1) != 0;
        l = ($urandom_range(2) == 0);
        d = 8'($urandom);
      end
      r0 = ($urandom_range(9) < 7);
      r1 = ($urandom_range(9) < 6);
      cyc(1'b1, v, s, l, d, r0, r1);
      hold = v && !rdy_e;
      checks++; if (rdy_s !== rdy_e) begin errors++; $display("FAIL rnd_in_ready[%0d] got %b exp %b", n, rdy_s, rdy_e); end
      checks++; if ({hs0_dut, hs0_dut_d} !== {hs0_mod, hs0_mod_d} && (hs0_dut || hs0_mod))
        begin errors++; $display("FAIL rnd_hs0[%0d] got hs%b %h exp hs%b %h", n, hs0_dut, hs0_dut_d, hs0_mod, hs0_mod_d); end
      checks++; if ({hs1_dut, hs1_dut_d} !== {hs1_mod, hs1_mod_d} && (hs1_dut || hs1_mod))
        begin errors++; $display("FAIL rnd_hs1[%0d] got hs%b %h exp hs%b %h", n, hs1_dut, hs1_dut_d, hs1_mod, hs1_mod_d); end
      checks++; if (out0_valid !== (mq0.size() != 0)) begin errors++; $display("FAIL rnd_out0_valid[%0d] got %b exp %b", n, out0_valid, (mq0.size() != 0)); end
      checks++; if (out1_valid !== (mq1.size() != 0)) begin errors++; $display("FAIL rnd_out1_valid[%0d] got %b exp %b", n, out1_valid, (mq1.size() != 0)); end
      checks++; if (busy !== m_inpkt) begin errors++; $display("FAIL rnd_busy[%0d] got %b exp %b", n, busy, m_inpkt); end
    end
`ifdef DEMUX_STATS_EN
    checks++; if (cnt0 !== m_cnt0) begin errors++; $display("FAIL rnd_cnt0 got %0d exp %0d", cnt0, m_cnt0); end
    checks++; if (cnt1 !== m_cnt1) begin errors++; $display("FAIL rnd_cnt1 got %0d exp %0d", cnt1, m_cnt1); end
`endif
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; in_sel = 1'b0; in_last = 1'b0; in_data = '0;
    out0_ready = 1'b0; out1_ready = 1'b0;
    rdy_s = 1'b0; rdy_e = 1'b0;
    test_reset();
    test_single_beat();
    test_sticky();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_packet();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux_1x2_stream.md
Name: demux_1x2_stream

Overview:
- Receive-side counterpart of the 2:1 select path: a 1-to-2 stream demultiplexer that routes a valid/ready input stream to one of two output streams.
- Destination comes from in_sel, sampled on the first beat of a packet and held (sticky) until the beat carrying in_last.
- Each output has a one-entry registered slot, so the outputs are registered and a stall on one output does not block draining of the other.
- Sits between a shared upstream source and two downstream consumers.

Parameters:
- WIDTH, 8, data bits per beat.
- CNT_W, 16, width of the optional per-output beat counters.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  synchronous active-low reset.
- in_data  input  WIDTH  input beat payload.
- in_sel  input  1  destination (0 → out0, 1 → out1); sampled only on the first beat of a packet.
- in_last  input  1  final beat of the packet.
- in_valid  input  1  input beat present.
- in_ready  output  1  block accepts the beat this cycle.
- out0_data  output  WIDTH  payload to consumer 0.
- out0_last  output  1  last flag to consumer 0.
- out0_valid  output  1  consumer 0 beat present.
- out0_ready  input  1  consumer 0 accepts.
- out1_data, out1_last, out1_valid, out1_ready: same as out0_* for consumer 1.
- busy  output  1  high while a multi-beat packet is mid-route.

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - state=IDLE.
  - out0_valid, out1_valid, out*_last = 0; out*_data = 0; busy = 0.
  - Any in_valid during reset is ignored.
- FSM states: IDLE, ROUTE0, ROUTE1.
- Destination dest:
  - IDLE: dest = in_sel.
  - ROUTE0: dest = 0, in_sel ignored.
  - ROUTE1: dest = 1, in_sel ignored.
- Slot free condition: slot[dest] is free when out_valid[dest]=0, or when out_valid[dest]=1 and out_ready[dest]=1 in the same cycle (drain and refill together).
- in_ready = slot[dest] free. in_ready is combinational from state, in_sel and out_ready[dest]; it never depends on in_valid.
- Accept: when in_valid & in_ready, slot[dest] loads in_data and in_last, and its valid is set at the next edge. Latency is 1 cycle.
- Transitions on accept:
  - IDLE with in_last=0 → ROUTE{in_sel}.
  - IDLE with in_last=1 → stays IDLE (single-beat packet).
  - ROUTEx with in_last=1 → IDLE.
  - ROUTEx with in_last=0 → stays ROUTEx.
- busy = (state != IDLE).
- Output rules:
  - While out_valid=1 and out_ready=0, out_data and out_last hold stable.
  - out_valid clears after a handshake unless refilled in that same cycle.
  - Slots drain independently; the non-destination slot continues to drain.
- Throughput: one beat per cycle when out_ready[dest] is held at 1.
- Upstream contract: upstream holds in_data, in_sel and in_last stable while in_valid=1 and in_ready=0. The block does not check this.
- Reset mid-packet: FSM returns to IDLE and both slots are emptied; held beats are discarded. The first beat after reset routes by its own in_sel.

Optional Feature:
- Macro: DEMUX_STATS_EN.
- Defined: adds output ports cnt0 and cnt1, each CNT_W bits.
  - cntN increments on every outN_valid & outN_ready handshake.
  - Wraps modulo 2^CNT_W.
  - Reset value 0.
- Undefined: cnt0/cnt1 ports and counter logic are absent; all other behaviour is identical.

Decomposition:
- Package demux_pkg:
  - state_t enum {IDLE, ROUTE0, ROUTE1}.
  - localparam N_OUT = 2.
- Sub-module demux_out_reg: one-entry slot instantiated twice.
  - Ports: clk, reset_n, load, d, d_last, ready, q, q_last, valid, free.
- The top level holds the FSM, dest select and in_ready.

Test Plan:
- Reset: reset_n=0 for 3 cycles with in_valid=1 → out0_valid=out1_valid=0, busy=0. After release with out0_ready=1 → in_ready=1.
- Single beat: in_data=8'hA5, in_sel=1, in_last=1, out1_ready=1 → next cycle out1_valid=1, out1_data=A5, out1_last=1. out0_valid stays 0, busy stays 0.
- Sticky packet: beats 11, 22, 33 with in_sel=0, 1, 1 and last on beat 33 → all three appear on out0. busy=1 after beat 11 and returns to 0 after beat 33.
- Backpressure: out0_ready=0, send beats 44 then 55 to out0 → 44 is held, in_ready=0 while 55 is presented. Raise out0_ready → 44 drains and 55 loads in the same cycle.
- Full rate with cross-route: out1_ready=1, 8 back-to-back beats → 8 out1 beats in consecutive cycles. Meanwhile a stalled out0 slot still drains when out0_ready rises.
- Reset mid-packet: in ROUTE1 with busy=1, assert reset_n=0 for one edge → state IDLE, both valids 0. The next beat with in_sel=0 appears on out0. With DEMUX_STATS_EN, cnt1 reads 0 after reset.
